// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: write port, two read addresses, clear request,
// registered read data and sweep-busy status.
interface register_bank_if #(
    parameter int unsigned N            = 32,
    parameter int unsigned address_size = 5
);
    logic                    Regwrite;
    logic [address_size-1:0] rs_address;
    logic [address_size-1:0] rt_address;
    logic [address_size-1:0] rd_address;
    logic [N-1:0]            write_data;
    logic                    clear_req;
    logic [N-1:0]            reg_A;
    logic [N-1:0]            reg_B;
    logic                    busy;

    modport master (
        output Regwrite, rs_address, rt_address, rd_address, write_data, clear_req,
        input  reg_A, reg_B, busy
    );

    modport slave (
        input  Regwrite, rs_address, rt_address, rd_address, write_data, clear_req,
        output reg_A, reg_B, busy
    );
endinterface

// File: rtl/register_bank.sv
// Two-read/one-write register file with $0 hardwired to zero and a hardware clear sweep.
// Define REGFILE_BYPASS_EN for write-first forwarding; otherwise reads see pre-write contents.
module register_bank #(
    parameter int unsigned N            = 32,
    parameter int unsigned address_size = 5
) (
    input  logic             clk,
    input  logic             reset,
    register_bank_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** address_size;
    localparam logic [address_size-1:0] LAST_ADDR = address_size'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    logic [address_size-1:0] clr_cnt;
    logic [N-1:0]            reg_a_q;
    logic [N-1:0]            reg_b_q;
    logic                    busy_q;

    logic [N-1:0]            mem [DEPTH];

    logic                    user_wr_c;
    logic                    wr_en_c;
    logic [address_size-1:0] wr_addr_c;
    logic [N-1:0]            wr_data_c;
    logic [N-1:0]            rd_a_c;
    logic [N-1:0]            rd_b_c;

    assign bus.reg_A = reg_a_q;
    assign bus.reg_B = reg_b_q;
    assign bus.busy  = busy_q;

    // Storage write port: the sweep owns it in CLEAR; clear_req beats a same-edge user write.
    always_comb begin
        user_wr_c = 1'b0;
        wr_en_c   = 1'b0;
        wr_addr_c = clr_cnt;
        wr_data_c = '0;
        if (state == RUN) begin
            user_wr_c = bus.Regwrite && !bus.clear_req && (bus.rd_address != '0);
            wr_en_c   = user_wr_c;
            wr_addr_c = bus.rd_address;
            wr_data_c = bus.write_data;
        end else begin
            wr_en_c   = 1'b1;
        end
    end

    // Read data selection for both ports; $0 always reads as zero.
    always_comb begin
        rd_a_c = mem[bus.rs_address];
        rd_b_c = mem[bus.rt_address];
`ifdef REGFILE_BYPASS_EN
        if (user_wr_c && (bus.rs_address == bus.rd_address)) begin
            rd_a_c = bus.write_data;
        end
        if (user_wr_c && (bus.rt_address == bus.rd_address)) begin
            rd_b_c = bus.write_data;
        end
`endif
        if (bus.rs_address == '0) begin
            rd_a_c = '0;
        end
        if (bus.rt_address == '0) begin
            rd_b_c = '0;
        end
    end

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[wr_addr_c] <= wr_data_c;
        end
    end

    // Sequencer: CLEAR sweeps every entry once, RUN serves reads and watches for clear_req.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            reg_a_q <= '0;
            reg_b_q <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    reg_a_q <= '0;
                    reg_b_q <= '0;
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= RUN;
                        busy_q  <= 1'b0;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + address_size'(1);
                    end
                end
                RUN: begin
                    reg_a_q <= rd_a_c;
                    reg_b_q <= rd_b_c;
                    if (bus.clear_req) begin
                        state   <= CLEAR;
                        busy_q  <= 1'b1;
                        clr_cnt <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    busy_q  <= 1'b1;
                    clr_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_register_bank.sv
// Randomized self-checking bench for register_bank against an array-based reference model.
module tb_register_bank;
    localparam int unsigned N     = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    int   vectors = 0;
    int   errors  = 0;

    register_bank_if #(.N(N), .address_size(AW)) bus ();

    register_bank #(.N(N), .address_size(AW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain array plus "edges of sweep remaining".
    logic [N-1:0] m [DEPTH];
    int           busy_left;
    logic [N-1:0] ea, eb, na, nb;
    logic         mwr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_left = DEPTH;
            ea = '0;
            eb = '0;
            for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            ea = '0;
            eb = '0;
        end else begin
            mwr = bus.Regwrite && !bus.clear_req && (bus.rd_address != 0);
            na = (bus.rs_address == 0) ? '0 : m[bus.rs_address];
            nb = (bus.rt_address == 0) ? '0 : m[bus.rt_address];
`ifdef REGFILE_BYPASS_EN
            if (mwr && bus.rs_address == bus.rd_address) na = bus.write_data;
            if (mwr && bus.rt_address == bus.rd_address) nb = bus.write_data;
`endif
            ea = na;
            eb = nb;
            if (bus.clear_req) begin
                busy_left = DEPTH;
                for (int i = 0; i < int'(DEPTH); i++) m[i] = '0;
            end else if (mwr) begin
                m[bus.rd_address] = bus.write_data;
            end
        end
    end

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_en) begin
                vectors++;
                if (bus.reg_A !== ea || bus.reg_B !== eb || bus.busy !== (busy_left != 0)) begin
                    errors++;
                    $display("FAIL cycle t=%0t reg_A=%h exp %h reg_B=%h exp %h busy=%b exp %b",
                             $time, bus.reg_A, ea, bus.reg_B, eb, bus.busy, (busy_left != 0));
                end
            end
        end
    endtask

    task automatic lit(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [N-1:0] wd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic clr);
        @(negedge clk);
        bus.Regwrite   = we;
        bus.rd_address = rd;
        bus.write_data = wd;
        bus.rs_address = rs;
        bus.rt_address = rt;
        bus.clear_req  = clr;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 200) begin
            idle();
            n++;
        end
        lit("wait_idle", N'(bus.busy), '0);
    endtask

    // Counts posedges until busy drops, bounded.
    task automatic count_busy(input string name, input int exp, input logic poke_write);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                bus.clear_req = 1'b0;
                if (poke_write) begin
                    bus.Regwrite   = 1'b1;
                    bus.rd_address = AW'(3);
                    bus.write_data = 32'h5A5A5A5A;
                end
            end else if (n == 2) begin
                bus.Regwrite = 1'b0;
            end
        end while (bus.busy && n < 100);
        lit(name, N'(n), N'(exp));
    endtask

    initial begin
        bus.Regwrite = 1'b0; bus.rd_address = '0; bus.write_data = '0;
        bus.rs_address = '0; bus.rt_address = '0; bus.clear_req = 1'b0;
        fork
            compare_loop();
        join_none

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        lit("reset_busy", N'(bus.busy), N'(1));
        lit("reset_reg_A", bus.reg_A, '0);
        lit("reset_reg_B", bus.reg_B, '0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        count_busy("sweep_len_after_reset", 32, 1'b0);

        for (int a = 1; a < int'(DEPTH); a++) drive(1'b0, '0, '0, AW'(a), AW'(DEPTH - a), 1'b0);

        drive(1'b1, AW'(5), 32'hDEADBEEF, '0, '0, 1'b0);
        drive(1'b1, AW'(31), 32'h12345678, '0, '0, 1'b0);
        drive(1'b0, '0, '0, AW'(5), AW'(31), 1'b0);
        @(posedge clk); #1;
        lit("rd_r5", bus.reg_A, 32'hDEADBEEF);
        lit("rd_r31", bus.reg_B, 32'h12345678);

        drive(1'b1, '0, 32'hFFFFFFFF, '0, '0, 1'b0);
        drive(1'b0, '0, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        lit("r0_A", bus.reg_A, '0);
        lit("r0_B", bus.reg_B, '0);

        drive(1'b1, AW'(7), 32'h11111111, '0, '0, 1'b0);
        drive(1'b1, AW'(7), 32'h22222222, AW'(7), '0, 1'b0);
        @(posedge clk); #1;
`ifdef REGFILE_BYPASS_EN
        lit("same_edge_r7", bus.reg_A, 32'h22222222);
`else
        lit("same_edge_r7", bus.reg_A, 32'h11111111);
`endif
        drive(1'b0, '0, '0, AW'(7), AW'(7), 1'b0);
        @(posedge clk); #1;
        lit("after_r7", bus.reg_A, 32'h22222222);

        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] rd, rs, rt;
            rd = AW'($urandom_range(0, DEPTH - 1));
            rs = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, DEPTH - 1));
            rt = ($urandom_range(0, 3) == 0) ? rd : AW'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 1)), rd, $urandom(), rs, rt,
                  ($urandom_range(0, 59) == 0));
        end
        wait_idle();

        for (int a = 1; a < int'(DEPTH); a++) drive(1'b1, AW'(a), $urandom() | 32'h1, '0, '0, 1'b0);
        drive(1'b1, AW'(3), 32'hAAAA5555, '0, '0, 1'b1);
        count_busy("sweep_len_clear_req", 33, 1'b1);
        drive(1'b0, '0, '0, AW'(3), AW'(31), 1'b0);
        @(posedge clk); #1;
        lit("cleared_r3", bus.reg_A, '0);
        lit("cleared_r31", bus.reg_B, '0);
        for (int a = 1; a < int'(DEPTH); a++) drive(1'b0, '0, '0, AW'(a), AW'(a), 1'b0);

        drive(1'b0, '0, '0, '0, '0, 1'b1);
        idle();
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        lit("midsweep_rst_A", bus.reg_A, '0);
        lit("midsweep_rst_B", bus.reg_B, '0);
        lit("midsweep_rst_busy", N'(bus.busy), N'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_busy("sweep_len_after_midsweep", 32, 1'b0);

        drive(1'b1, AW'(9), 32'h9999AAAA, '0, '0, 1'b0);
        drive(1'b0, '0, '0, AW'(9), AW'(9), 1'b0);
        @(posedge clk); #1;
        lit("pre_run_rst", bus.reg_A, 32'h9999AAAA);
        #1 rst_n = 1'b0;
        #1;
        lit("run_rst_A", bus.reg_A, '0);
        lit("run_rst_busy", N'(bus.busy), N'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        drive(1'b0, '0, '0, AW'(9), AW'(5), 1'b0);
        idle();
        idle();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/register_bank.md
# register_bank

Parametrised two-read/one-write register file for the multi-cycle MIPS datapath, replacing the fixed 32×32 array. It adds a hardware clear sequencer that zeroes every entry after reset or on request, since block-RAM storage cannot be reset directly. Register $0 is hardwired to zero. Reads stay registered, with one-cycle latency, so the A/B operand latches in the multi-cycle FSM keep their timing.

## Interface
- N, 32: data width in bits.
- address_size, 5: address width; depth DEPTH = 2**address_size entries.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- Regwrite  in  1  write enable for port rd.
- rs_address  in  address_size  read address, port A.
- rt_address  in  address_size  read address, port B.
- rd_address  in  address_size  write address.
- write_data  in  N  write data.
- clear_req  in  1  one-cycle pulse; requests a full zeroing sweep.
- reg_A  out  N  registered read data, port A.
- reg_B  out  N  registered read data, port B.
- busy  out  1  high while the clear sweep runs; writes are ignored.

## Operation
- FSM states are CLEAR and RUN. A counter clr_cnt of width address_size tracks the sweep.
- Reset asserted (reset=0): state=CLEAR, clr_cnt=0, reg_A=0, reg_B=0, busy=1. Array contents are not touched asynchronously.
- CLEAR, each edge:
  - mem[clr_cnt] <= 0.
  - If clr_cnt==DEPTH-1: state<=RUN, busy<=0, clr_cnt<=0. Otherwise clr_cnt<=clr_cnt+1.
  - reg_A and reg_B load 0.
  - Regwrite is ignored.
  - clear_req is ignored; the sweep does not restart.
- RUN, each edge:
  - If clear_req=1: state<=CLEAR, busy<=1, clr_cnt<=0. Any Regwrite on the same edge is dropped, because clear wins.
  - Else if Regwrite=1 and rd_address!=0: mem[rd_address] <= write_data.
  - A write to address 0 is discarded.
  - reg_A <= rd(rs_address) and reg_B <= rd(rt_address), where rd(a) = 0 if a==0, else per the bypass rule in Configuration, else mem[a].
- Both read ports are independent. rs_address==rt_address is legal, and both ports return the same value.
- All arithmetic is unsigned. clr_cnt wraps only via the explicit DEPTH-1 compare.

## Timing
- Read latency is 1 cycle: an address presented before edge k gives data on reg_A/reg_B after edge k.
- Write latency is 1 cycle. A read of the same address on the same edge returns the old value unless bypass is enabled.
- Clear sweep takes exactly DEPTH edges after reset deasserts, or after the clear_req edge. busy falls on the DEPTH-th edge.
  - For address_size=5: busy is high for 32 cycles after release, or for 33 edges counting the request edge for clear_req.
- Reset asserted mid-sweep or mid-RUN:
  - Outputs go to their reset values immediately.
  - After release the sweep restarts from entry 0.
  - Partially written data is not guaranteed.
- The first valid write is accepted on the first edge with busy=0.

## Configuration
- REGFILE_BYPASS_EN defined: write-first forwarding is enabled.
  - In RUN, if Regwrite=1, rd_address!=0, clear_req=0 and a read address equals rd_address, that port loads write_data on the same edge.
- REGFILE_BYPASS_EN undefined: read-before-write. The port loads the pre-write mem contents.
  - This matches the current multi-cycle control, which never reads a register in its write cycle.
- $0 forcing and the clear sequencer are present in both builds.

## Test plan
- Reset and sweep: hold reset=0 for 3 cycles, then release.
  - busy=1 for exactly 32 edges, then 0.
  - Reading addresses 1..31 afterwards returns 0x00000000.
- Write/read: write 0xDEADBEEF to r5, and 0x12345678 to r31 on the next edge, then read rs=5, rt=31.
  - reg_A=0xDEADBEEF and reg_B=0x12345678, one cycle after the address.
- Zero register: write 0xFFFFFFFF to r0, then read rs=0, rt=0.
  - Both outputs are 0x00000000.
- Same-edge read/write: with r7=0x11111111, write 0x22222222 to r7 while rs=7 on the same edge.
  - Bypass build: reg_A=0x22222222.
  - Non-bypass build: reg_A=0x11111111.
  - The next read returns 0x22222222 in both builds.
- Clear request: fill r1..r31 with nonzero data, pulse clear_req together with Regwrite to r3=0xAAAA5555.
  - The write is dropped and busy=1 for 32 cycles.
  - A Regwrite during busy is ignored.
  - All registers then read 0.
- Reset mid-sweep: assert reset at clr_cnt=10, release after 2 cycles.
  - reg_A=reg_B=0 immediately and busy=1.
  - A full 32-cycle sweep follows.
